// File: rtl/pwm_pkg.sv
// Shared constants for the PWM configuration scheduler: channel group map,
// write-select codes and commit FSM state encoding.
package pwm_pkg;
  localparam int NUM_GRP = 4;
  localparam int GRP_BASE [NUM_GRP] = '{0, 8, 12, 16};
  localparam int GRP_SIZE [NUM_GRP] = '{8, 4, 4, 8};
  // Channels from this index on (grp3) keep only a 32-bit value.
  localparam int NARROW_BASE = 16;

  localparam logic SEL_DIV  = 1'b0;
  localparam logic SEL_DUTY = 1'b1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
endpackage

// File: rtl/pwm_cfg_sched_if.sv
// Request/commit bundle of pwm_cfg_sched. master = register layer + PWM side,
// slave = scheduler.
interface pwm_cfg_sched_if #(
  parameter int NUM_REQ = 3,
  parameter int CH_AW   = 5,
  parameter int DW      = 64
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][CH_AW-1:0] req_ch;
  logic [NUM_REQ-1:0]            req_sel;
  logic [NUM_REQ-1:0][DW-1:0]    req_data;
  logic [3:0]                    grp_sync;
  logic                          upd_valid;
  logic [CH_AW-1:0]              upd_ch;
  logic [DW-1:0]                 upd_div;
  logic [DW-1:0]                 upd_duty;
  logic                          busy;

  modport master (
    output req_valid, req_ch, req_sel, req_data, grp_sync,
    input  req_ready, upd_valid, upd_ch, upd_div, upd_duty, busy
  );
  modport slave (
    input  req_valid, req_ch, req_sel, req_data, grp_sync,
    output req_ready, upd_valid, upd_ch, upd_div, upd_duty, busy
  );
endinterface

// File: rtl/pwm_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, priority starts at the
// index after the last winner; pointer only moves when something is granted.
module pwm_rr_arb #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int            r;

  // Scan from the far end so the nearest valid index to ptr_q wins last.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    r     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      r = (int'(ptr_q) + k) % NUM_REQ;
      if (valid_i[r]) begin
        gnt_o    = '0;
        gnt_o[r] = 1'b1;
        ptr_d    = PW'((r + 1) % NUM_REQ);
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/pwm_cfg_sched.sv
// PWM configuration scheduler: arbitrates shadow writes from several
// requesters and commits pending channels of a group one per cycle after that
// group's period restart. Optional feature macro: PWM_FAILSAFE_EN (adds the
// failsafe input that zeroes every shadow duty and blocks requesters).
module pwm_cfg_sched
  import pwm_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int NUM_CH  = 24,
  parameter int CH_AW   = 5,
  parameter int DW      = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef PWM_FAILSAFE_EN
  input  logic failsafe,
`endif
  pwm_cfg_sched_if.slave bus
);
  logic [NUM_CH-1:0][DW-1:0] div_q, duty_q;
  logic [NUM_CH-1:0]         pend_q;
  logic [3:0]                sync_pend_q, sp_clr;
  logic [0:0]                state_q, state_d;
  logic [CH_AW-1:0]          idx_q, idx_d;
  logic [1:0]                grp_q, grp_d, pick_g;
  logic                      pick_vld, scan_last, commit;

  logic                      upd_valid_q;
  logic [CH_AW-1:0]          upd_ch_q;
  logic [DW-1:0]             upd_div_q, upd_duty_q;

  logic [NUM_REQ-1:0]        arb_vld, gnt;
  logic                      wr_en, wr_ok, wr_sel;
  logic [CH_AW-1:0]          wr_ch;
  logic [DW-1:0]             wr_data, wr_val;

`ifdef PWM_FAILSAFE_EN
  assign arb_vld = failsafe ? '0 : bus.req_valid;
`else
  assign arb_vld = bus.req_valid;
`endif

  pwm_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (arb_vld),
    .gnt_o   (gnt)
  );
  assign bus.req_ready = gnt;

  // Mux the granted requester's write onto one write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_sel  = SEL_DIV;
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        wr_en   = 1'b1;
        wr_ch   = bus.req_ch[i];
        wr_sel  = bus.req_sel[i];
        wr_data = bus.req_data[i];
      end
    end
  end

  // Out-of-range channels are handshaken but dropped; grp3 stores 32 bits.
  assign wr_ok  = wr_en && (32'(wr_ch) < NUM_CH);
  assign wr_val = (32'(wr_ch) >= NARROW_BASE) ? {{(DW-32){1'b0}}, wr_data[31:0]} : wr_data;

  // Commit FSM next state: lowest pending group first, then one channel/cycle.
  always_comb begin
    pick_vld = 1'b0;
    pick_g   = '0;
    for (int g = 3; g >= 0; g--) begin
      if (sync_pend_q[g]) begin
        pick_vld = 1'b1;
        pick_g   = 2'(g);
      end
    end
    scan_last = (32'(idx_q) == 32'(GRP_BASE[grp_q] + GRP_SIZE[grp_q] - 1));
    state_d   = state_q;
    idx_d     = idx_q;
    grp_d     = grp_q;
    sp_clr    = '0;
    case (state_q)
      IDLE: if (pick_vld) begin
        sp_clr[pick_g] = 1'b1;
        grp_d          = pick_g;
        idx_d          = CH_AW'(GRP_BASE[pick_g]);
        state_d        = SCAN;
      end
      SCAN: begin
        idx_d = idx_q + CH_AW'(1);
        if (scan_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit = (state_q == SCAN) && pend_q[idx_q];

  // FSM and sync-pending registers; a new pulse wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      grp_q       <= '0;
      sync_pend_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      grp_q       <= grp_d;
      sync_pend_q <= (sync_pend_q & ~sp_clr) | bus.grp_sync;
    end
  end

  // Shadow values and pend bits; a same-cycle write re-arms pend after commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      duty_q <= '0;
      pend_q <= '0;
    end else begin
`ifdef PWM_FAILSAFE_EN
      if (failsafe) begin
        duty_q <= '0;
        pend_q <= '1;
      end else begin
`else
      begin
`endif
        if (commit) pend_q[idx_q] <= 1'b0;
        if (wr_ok) begin
          if (wr_sel == SEL_DUTY) duty_q[wr_ch] <= wr_val;
          else                    div_q[wr_ch]  <= wr_val;
          pend_q[wr_ch] <= 1'b1;
        end
      end
    end
  end

  // Registered commit port; duty above the divider is clamped to 100%.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
      upd_div_q   <= '0;
      upd_duty_q  <= '0;
    end else begin
      upd_valid_q <= commit;
      if (commit) begin
        upd_ch_q   <= idx_q;
        upd_div_q  <= div_q[idx_q];
        upd_duty_q <= (duty_q[idx_q] > div_q[idx_q]) ? div_q[idx_q] : duty_q[idx_q];
      end
    end
  end

  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_ch    = upd_ch_q;
  assign bus.upd_div   = upd_div_q;
  assign bus.upd_duty  = upd_duty_q;
  assign bus.busy      = (state_q == SCAN);
endmodule

// File: tb/tb_pwm_cfg_sched.sv
// Bench for pwm_cfg_sched: reset checks, arbiter ordering, a vector table of
// write/commit cases, hand sequences for multi-cycle corners, then random
// traffic against a group/position level reference model.
module tb_pwm_cfg_sched;
  import pwm_pkg::*;
  localparam int NR = 3, NC = 24, AW = 5, DW = 64;

  logic clk = 1'b0;
  logic rst;
`ifdef PWM_FAILSAFE_EN
  logic failsafe;
`endif

  pwm_cfg_sched_if #(.NUM_REQ(NR), .CH_AW(AW), .DW(DW)) bus ();

  pwm_cfg_sched #(.NUM_REQ(NR), .NUM_CH(NC), .CH_AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef PWM_FAILSAFE_EN
    .failsafe (failsafe),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          ch;
    int          g;
    logic [63:0] div, duty, ediv, eduty;
  } vec_t;
  vec_t tbl [7];

  // reference model
  logic [63:0] m_div [NC];
  logic [63:0] m_duty [NC];
  bit          m_pend [NC];
  bit   [3:0]  m_sp;
  int          m_grp, m_pos, m_ptr;
  bit          e_uv;
  int          e_uch;
  logic [63:0] e_ud, e_uy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.req_valid = '0;
    bus.req_ch    = '0;
    bus.req_sel   = '0;
    bus.req_data  = '0;
    bus.grp_sync  = '0;
  endtask

  task automatic sync(input logic [3:0] m);
    bus.grp_sync = m;
    step();
    bus.grp_sync = '0;
  endtask

  task automatic wr(input int r, input int ch, input logic sel, input logic [63:0] d);
    bit done;
    done = 1'b0;
    bus.req_valid[r] = 1'b1;
    bus.req_ch[r]    = AW'(ch);
    bus.req_sel[r]   = sel;
    bus.req_data[r]  = d;
    for (int n = 0; n < 2 * NR && !done; n++) begin
      #1;
      if (bus.req_ready[r]) done = 1'b1;
      step();
    end
    bus.req_valid[r] = 1'b0;
    chk("wr_grant", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NC; i++) begin
      m_div[i] = '0; m_duty[i] = '0; m_pend[i] = 1'b0;
    end
    m_sp = '0; m_grp = -1; m_pos = 0; m_ptr = 0;
    e_uv = 1'b0; e_uch = 0; e_ud = '0; e_uy = '0;
  endtask

  function automatic int grp_of(input int ch);
    return (ch < 8) ? 0 : (ch < 12) ? 1 : (ch < 16) ? 2 : 3;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gi, c, wc, ng, cnt;
    logic [63:0] v;
    int q [$];
    bit seen [NC];

    tbl[0] = '{2,  0, 64'd1000, 64'd250, 64'd1000, 64'd250};
    tbl[1] = '{17, 3, 64'd3000, 64'd5000, 64'd3000, 64'd3000};
    tbl[2] = '{9,  1, 64'hFFFF_0000_0000_0010, 64'h5, 64'hFFFF_0000_0000_0010, 64'h5};
    tbl[3] = '{23, 3, 64'hABCD_0000_0000_1000, 64'h1234_0000_0000_0800, 64'h1000, 64'h800};
    tbl[4] = '{15, 2, 64'd100, 64'd100, 64'd100, 64'd100};
    tbl[5] = '{12, 2, 64'd0, 64'd7, 64'd0, 64'd0};
    tbl[6] = '{30, 0, 64'd5, 64'd5, 64'd0, 64'd0};

`ifdef PWM_FAILSAFE_EN
    failsafe = 1'b0;
`endif
    do_reset();

    // reset state
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
    chk("rst_upd_ch", 64'(bus.upd_ch), 64'd0);
    chk("rst_upd_div", bus.upd_div, 64'd0);
    chk("rst_upd_duty", bus.upd_duty, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    step();

    // arbiter fairness; channel 31 writes are dropped
    bus.req_ch = {NR{AW'(31)}};
    bus.req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_all", 64'(bus.req_ready), 64'd1 << (i % 3));
      step();
    end
    bus.req_valid = 3'b101;
    #1 chk("rr_101_a", 64'(bus.req_ready), 64'd1); step();
    #1 chk("rr_101_b", 64'(bus.req_ready), 64'd4); step();
    #1 chk("rr_101_c", 64'(bus.req_ready), 64'd1); step();
    clr_in();

    // vector table: write div+duty, sync the group, expect one commit at t+2+k
    for (int e = 0; e < 7; e++) begin
      int expk;
      wr(e % NR, tbl[e].ch, SEL_DIV, tbl[e].div);
      wr(e % NR, tbl[e].ch, SEL_DUTY, tbl[e].duty);
      sync(4'(1 << tbl[e].g));
      expk = (tbl[e].ch < NC) ? 2 + tbl[e].ch - GRP_BASE[tbl[e].g] : -1;
      for (int k = 0; k < 12; k++) begin
        if (k == expk) begin
          chk($sformatf("tbl%0d_valid", e), 64'(bus.upd_valid), 64'd1);
          chk($sformatf("tbl%0d_ch", e), 64'(bus.upd_ch), 64'(tbl[e].ch));
          chk($sformatf("tbl%0d_div", e), bus.upd_div, tbl[e].ediv);
          chk($sformatf("tbl%0d_duty", e), bus.upd_duty, tbl[e].eduty);
        end else begin
          chk($sformatf("tbl%0d_idle_k%0d", e, k), 64'(bus.upd_valid), 64'd0);
        end
        step();
      end
    end

    // two groups synced together: grp0 fully, then grp3, busy 16 cycles
    for (int ch = 0; ch < 8; ch++) begin
      wr(ch % NR, ch, SEL_DIV, 64'(1000 + ch));
      wr(ch % NR, 16 + ch, SEL_DIV, 64'(2000 + ch));
    end
    sync(4'b1001);
    cnt = 0;
    q.delete();
    for (int k = 0; k < 24; k++) begin
      if (bus.upd_valid) q.push_back(int'(bus.upd_ch));
      if (bus.busy) cnt++;
      step();
    end
    chk("multi_busy_cycles", 64'(cnt), 64'd16);
    chk("multi_count", 64'(q.size()), 64'd16);
    for (int i = 0; i < q.size() && i < 16; i++)
      chk($sformatf("multi_order%0d", i), 64'(q[i]), 64'((i < 8) ? i : 8 + i));

    // write racing the commit of the same channel
    wr(0, 5, SEL_DIV, 64'd10);
    wr(0, 5, SEL_DUTY, 64'd5);
    sync(4'b0001);
    repeat (6) step();
    bus.req_valid[1] = 1'b1; bus.req_ch[1] = AW'(5);
    bus.req_sel[1] = SEL_DUTY; bus.req_data[1] = 64'd9;
    #1 chk("race_ready", 64'(bus.req_ready), 64'd2);
    step();
    bus.req_valid[1] = 1'b0;
    chk("race_old_valid", 64'(bus.upd_valid), 64'd1);
    chk("race_old_ch", 64'(bus.upd_ch), 64'd5);
    chk("race_old_duty", bus.upd_duty, 64'd5);
    repeat (5) step();
    sync(4'b0001);
    repeat (7) step();
    chk("race_new_valid", 64'(bus.upd_valid), 64'd1);
    chk("race_new_ch", 64'(bus.upd_ch), 64'd5);
    chk("race_new_div", bus.upd_div, 64'd10);
    chk("race_new_duty", bus.upd_duty, 64'd9);
    repeat (4) step();

`ifdef PWM_FAILSAFE_EN
    // failsafe mid-scan: no grants, every channel later commits duty 0
    wr(0, 1, SEL_DIV, 64'd200);
    wr(0, 1, SEL_DUTY, 64'd100);
    wr(0, 13, SEL_DIV, 64'd50);
    wr(0, 13, SEL_DUTY, 64'd20);
    for (int i = 0; i < NC; i++) seen[i] = 1'b0;
    sync(4'b0001);
    repeat (2) step();
    failsafe = 1'b1;
    bus.req_valid = 3'b111;
    #1 chk("fs_ready", 64'(bus.req_ready), 64'd0);
    step();
    failsafe = 1'b0;
    bus.req_valid = '0;
    for (int k = 0; k < 12; k++) begin
      if (bus.upd_valid && bus.upd_duty == 0) seen[bus.upd_ch] = 1'b1;
      step();
    end
    for (int g = 0; g < 4; g++) begin
      sync(4'(1 << g));
      for (int k = 0; k < 12; k++) begin
        if (bus.upd_valid) begin
          chk("fs_duty0", bus.upd_duty, 64'd0);
          if (bus.upd_ch == 13) chk("fs_div13", bus.upd_div, 64'd50);
          if (bus.upd_ch == 1) chk("fs_div1", bus.upd_div, 64'd200);
          seen[bus.upd_ch] = 1'b1;
        end
        step();
      end
    end
    cnt = 0;
    for (int i = 0; i < NC; i++) cnt += int'(seen[i]);
    chk("fs_all_channels", 64'(cnt), 64'(NC));
`endif

    // async reset mid-scan drops outputs, pend and shadow at once
    wr(0, 3, SEL_DIV, 64'd77);
    wr(1, 6, SEL_DUTY, 64'd9);
    sync(4'b0001);
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_upd_valid", 64'(bus.upd_valid), 64'd0);
    chk("arst_upd_div", bus.upd_div, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wr(2, 3, SEL_DUTY, 64'd5);
    sync(4'b0001);
    for (int k = 0; k < 12; k++) begin
      if (k == 5) begin
        chk("arst_ch3_valid", 64'(bus.upd_valid), 64'd1);
        chk("arst_ch3_div", bus.upd_div, 64'd0);
        chk("arst_ch3_duty", bus.upd_duty, 64'd0);
      end else begin
        chk($sformatf("arst_idle_k%0d", k), 64'(bus.upd_valid), 64'd0);
      end
      step();
    end

    // random traffic against the reference model
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        bus.req_valid[r] = 1'($urandom_range(0, 1));
        bus.req_ch[r]    = AW'($urandom_range(0, 31));
        bus.req_sel[r]   = 1'($urandom_range(0, 1));
        bus.req_data[r]  = {$urandom, $urandom};
      end
      for (int g = 0; g < 4; g++) bus.grp_sync[g] = ($urandom_range(0, 15) == 0);
      #1;
      gi = -1;
      for (int k = 0; k < NR; k++)
        if (gi < 0 && bus.req_valid[(m_ptr + k) % NR]) gi = (m_ptr + k) % NR;
      chk("rnd_ready", 64'(bus.req_ready), (gi < 0) ? 64'd0 : (64'd1 << gi));
      chk("rnd_busy", 64'(bus.busy), 64'(m_grp >= 0));
      chk("rnd_upd_valid", 64'(bus.upd_valid), 64'(e_uv));
      if (e_uv) begin
        chk("rnd_upd_ch", 64'(bus.upd_ch), 64'(e_uch));
        chk("rnd_upd_div", bus.upd_div, e_ud);
        chk("rnd_upd_duty", bus.upd_duty, e_uy);
      end
      // advance the model across the coming edge
      e_uv = 1'b0;
      if (m_grp >= 0) begin
        c = GRP_BASE[m_grp] + m_pos;
        if (m_pend[c]) begin
          e_uv = 1'b1; e_uch = c; e_ud = m_div[c];
          e_uy = (m_duty[c] > m_div[c]) ? m_div[c] : m_duty[c];
          m_pend[c] = 1'b0;
        end
      end
      if (gi >= 0) begin
        wc = int'(bus.req_ch[gi]);
        if (wc < NC) begin
          v = bus.req_data[gi];
          if (grp_of(wc) == 3) v = v & 64'hFFFF_FFFF;
          if (bus.req_sel[gi] == SEL_DUTY) m_duty[wc] = v;
          else m_div[wc] = v;
          m_pend[wc] = 1'b1;
        end
        m_ptr = (gi + 1) % NR;
      end
      if (m_grp >= 0) begin
        if (m_pos == GRP_SIZE[m_grp] - 1) m_grp = -1;
        else m_pos++;
      end else begin
        ng = -1;
        for (int g = 3; g >= 0; g--) if (m_sp[g]) ng = g;
        if (ng >= 0) begin
          m_grp = ng; m_pos = 0; m_sp[ng] = 1'b0;
        end
      end
      m_sp = m_sp | bus.grp_sync;
      @(posedge clk);
      #1;
    end
    clr_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
